// File: rtl/cpu_pkg.sv
// Shared core definitions: control-kind encoding, default PC arithmetic
// constants and the link register index.
package cpu_pkg;

  typedef enum logic [1:0] {
    CTL_SEQ = 2'd0,
    CTL_BR  = 2'd1,
    CTL_BL  = 2'd2,
    CTL_RET = 2'd3
  } ctl_kind_e;

  localparam int unsigned PC_STEP_DEF  = 4;
  localparam int unsigned PIPE_ADJ_DEF = 8;
  localparam logic [3:0]  R14_IDX      = 4'd14;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the decode stage (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned OFF_W     = 24,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic [1:0]        ctl_kind;
  logic [OFF_W-1:0]  br_offset;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link_addr;
  logic              link_we;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_underflow;
  logic              ras_overflow;

  modport master (
    output stall, ctl_kind, br_offset,
    input  pc, link_addr, link_we, ras_count, ras_underflow, ras_overflow
  );

  modport slave (
    input  stall, ctl_kind, br_offset,
    output pc, link_addr, link_we, ras_count, ras_underflow, ras_overflow
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d, wr_ptr;
  logic [CNT_W-1:0] count_q, count_d;

  assign wr_ptr     = top_q + PTR_W'(1);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign top_data_o = mem_q[top_q];

  // The slot after top is either free or the oldest entry, so a full push
  // naturally overwrites the oldest one.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    if (push_i) begin
      top_d = wr_ptr;
      if (!full_o) count_d = count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '1;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered next-PC unit: sequential/branch/branch-with-link/return selection
// with stall hold, return-address stack and link-register write strobe.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned      ADDR_W    = 32,
  parameter int unsigned      OFF_W     = 24,
  parameter int unsigned      PC_STEP   = PC_STEP_DEF,
  parameter int unsigned      PIPE_ADJ  = PIPE_ADJ_DEF,
  parameter int unsigned      RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic              link_we_q, link_we_d;
  logic              unf_q, unf_d;
  logic              ovf_q, ovf_d;

  logic [ADDR_W-1:0] seq_pc, tgt, off_ext;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_push, ras_pop, ras_full, ras_empty;
  ctl_kind_e         kind;

  assign kind    = ctl_kind_e'(bus.ctl_kind);
  assign off_ext = ADDR_W'($signed(bus.br_offset));
  assign seq_pc  = pc_q + ADDR_W'(PC_STEP);
  assign tgt     = pc_q + (off_ext << 2) + ADDR_W'(PIPE_ADJ);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (seq_pc),
    .top_data_o  (ras_top),
    .count_o     (ras_cnt),
    .full_o      (ras_full),
    .empty_o     (ras_empty)
  );

  always_comb begin
    pc_d        = pc_q;
    link_addr_d = link_addr_q;
    link_we_d   = 1'b0;
    unf_d       = 1'b0;
    ovf_d       = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    if (!bus.stall) begin
      unique case (kind)
        CTL_SEQ: pc_d = seq_pc;
        CTL_BR:  pc_d = tgt;
        CTL_BL: begin
          pc_d        = tgt;
          link_addr_d = seq_pc;
          link_we_d   = 1'b1;
          ras_push    = 1'b1;
          ovf_d       = ras_full;
        end
        CTL_RET: begin
          if (ras_empty) begin
            pc_d  = seq_pc;
            unf_d = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      link_addr_q <= '0;
      link_we_q   <= 1'b0;
      unf_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      link_addr_q <= link_addr_d;
      link_we_q   <= link_we_d;
      unf_q       <= unf_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.link_addr     = link_addr_q;
  assign bus.link_we       = link_we_q;
  assign bus.ras_count     = ras_cnt;
  assign bus.ras_underflow = unf_q;
  assign bus.ras_overflow  = ovf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed sequences then random control,
// checked against a queue-based reference model.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned OFF_W     = 24;
  localparam int unsigned RAS_DEPTH = 4;
  localparam logic [31:0] RST_PC    = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        link_we;
    logic [31:0] cnt;
    logic        unf;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_sequencer #(
    .ADDR_W    (ADDR_W),
    .OFF_W     (OFF_W),
    .PC_STEP   (4),
    .PIPE_ADJ  (8),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_link = 32'h0;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of control and predict the state after the next edge.
  task automatic step(input logic rst, input logic stl, input logic [1:0] kind,
                      input logic [23:0] off);
    exp_t e;
    logic [31:0] tgt;
    @(negedge clk);
    reset         = rst;
    bus.stall     = stl;
    bus.ctl_kind  = kind;
    bus.br_offset = off;
    tgt = m_pc + ({{8{off[23]}}, off} * 4) + 32'd8;
    e.link_we = 1'b0;
    e.unf     = 1'b0;
    e.ovf     = 1'b0;
    if (rst) begin
      m_pc   = RST_PC;
      m_link = 32'h0;
      m_ras.delete();
    end else if (!stl) begin
      case (kind)
        2'd0: m_pc = m_pc + 4;
        2'd1: m_pc = tgt;
        2'd2: begin
          m_link    = m_pc + 4;
          e.link_we = 1'b1;
          m_ras.push_back(m_pc + 4);
          if (m_ras.size() > RAS_DEPTH) begin
            void'(m_ras.pop_front());
            e.ovf = 1'b1;
          end
          m_pc = tgt;
        end
        default: begin
          if (m_ras.size() == 0) begin
            m_pc  = m_pc + 4;
            e.unf = 1'b1;
          end else begin
            m_pc = m_ras.pop_back();
          end
        end
      endcase
    end
    e.pc        = m_pc;
    e.link_addr = m_link;
    e.cnt       = m_ras.size();
    exp_q.push_back(e);
  endtask

  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] d;
    d = target - m_pc - 32'd8;
    step(1'b0, 1'b0, 2'd1, d[25:2]);
  endtask

  // Monitor: every edge presents a new state; compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",        bus.pc,                     e.pc);
        chk("link_we",   {31'b0, bus.link_we},       {31'b0, e.link_we});
        chk("link_addr", bus.link_addr,              e.link_addr);
        chk("ras_count", 32'(bus.ras_count),         e.cnt);
        chk("underflow", {31'b0, bus.ras_underflow}, {31'b0, e.unf});
        chk("overflow",  {31'b0, bus.ras_overflow},  {31'b0, e.ovf});
      end
    end
  end

  initial begin
    int budget;
    reset         = 1'b1;
    bus.stall     = 1'b0;
    bus.ctl_kind  = 2'd0;
    bus.br_offset = '0;

    // Reset then sequential fetch
    step(1'b1, 1'b0, 2'd0, 24'h0);
    repeat (3) step(1'b0, 1'b0, 2'd0, 24'h0);

    // Forward and backward branch
    goto_pc(32'h100);
    step(1'b0, 1'b0, 2'd1, 24'h000010);
    step(1'b0, 1'b0, 2'd1, 24'hFFFFFE);

    // Call and return
    goto_pc(32'h200);
    step(1'b0, 1'b0, 2'd2, 24'h000020);
    step(1'b0, 1'b0, 2'd3, 24'h0);

    // Overflow and underflow of the return stack
    step(1'b1, 1'b0, 2'd0, 24'h0);
    repeat (5) step(1'b0, 1'b0, 2'd2, 24'h000010);
    repeat (5) step(1'b0, 1'b0, 2'd3, 24'h0);

    // Stall ignores a pending branch
    step(1'b0, 1'b0, 2'd2, 24'h000004);
    repeat (3) step(1'b0, 1'b1, 2'd1, 24'h000100);
    step(1'b0, 1'b0, 2'd0, 24'h0);

    // Reset wins over a call with a non-empty stack
    step(1'b0, 1'b0, 2'd2, 24'h000008);
    step(1'b1, 1'b0, 2'd2, 24'h000008);
    step(1'b1, 1'b1, 2'd3, 24'h0);

    // Random mix
    for (int i = 0; i < 400; i++) begin
      logic [23:0] off;
      off = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 63) - 32);
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
           2'($urandom_range(0, 3)), off);
    end

    step(1'b0, 1'b0, 2'd0, 24'h0);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered next-PC unit for the single-issue ARM-style core; it owns the architectural fetch PC.
- Each cycle it selects sequential, branch, branch-with-link or return, and drives the fetch address to instruction memory.
- Adds what the combinational next-PC logic lacked: stall hold, a parametrised return-address stack (RAS), a link-register write strobe and a configurable reset vector.

Parameters:
- ADDR_W, 32, PC and address width.
- OFF_W, 24, width of the signed word offset carried in the branch instruction.
- PC_STEP, 4, sequential increment in bytes.
- PIPE_ADJ, 8, pipeline read-ahead added to branch targets (ARM PC+8 semantics).
- RAS_DEPTH, 4, number of return-address stack entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS; ignore the control inputs this cycle.
- ctl_kind  in  2  0=SEQ, 1=BR, 2=BL, 3=RET; sampled when stall=0.
- br_offset  in  OFF_W  signed word offset for BR and BL.
- pc  out  ADDR_W  current fetch address (registered).
- link_addr  out  ADDR_W  return address to be written to r14.
- link_we  out  1  one-cycle strobe; link_addr is valid for r14.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_underflow  out  1  one-cycle pulse when RET is issued with an empty RAS.
- ras_overflow  out  1  one-cycle pulse when BL is issued with a full RAS.

Behaviour:
- Reset (synchronous; has priority over everything): pc=RESET_PC, link_addr=0, link_we=0, ras_count=0, ras_underflow=0, ras_overflow=0. RAS contents are don't-care.
- Branch target: tgt = pc + (sign_extend(br_offset, ADDR_W) << 2) + PIPE_ADJ.
  - Computed modulo 2^ADDR_W; wrap-around is silent.
- Per-edge update when stall=0:
  - SEQ: pc <= pc+PC_STEP.
  - BR: pc <= tgt.
  - BL:
    - pc <= tgt
    - link_addr <= pc+PC_STEP, link_we <= 1
    - push pc+PC_STEP onto the RAS.
  - RET, RAS non-empty: pc <= top of stack; pop.
  - RET, RAS empty: pc <= pc+PC_STEP, ras_underflow <= 1, no pop.
- Latency: the new pc is visible one cycle after the control is sampled. link_we and the flag pulses are also registered, coincident with the new pc, and last one cycle.
- stall=1: pc, RAS and ras_count hold. link_we, ras_underflow and ras_overflow are 0. ctl_kind and br_offset are ignored; they are not queued.
- RAS is a circular buffer with a top pointer.
  - Push when full overwrites the oldest entry; ras_count stays at RAS_DEPTH; ras_overflow pulses.
  - Pop decrements ras_count. Pointers wrap modulo RAS_DEPTH.
- There is no simultaneous push and pop; ctl_kind is single-valued.
- Reset asserted together with stall or any ctl_kind: reset wins.
- Reset mid-sequence empties the RAS.
- link_addr holds its last value when link_we=0.

Decomposition:
- Shared package (cpu_pkg) holds:
  - the ctl_kind encoding constants CTL_SEQ=0, CTL_BR=1, CTL_BL=2, CTL_RET=3;
  - the PC_STEP and PIPE_ADJ defaults;
  - the r14 register index.
- One natural sub-module: ras_stack (parametrised by depth and width).
  - Ports: push, pop, push_data, top_data, count, full, empty.
  - Circular overwrite-on-full behaviour.
- The target adder and the next-PC mux stay in pc_sequencer.

Test Plan:
- Reset, then 3 cycles of SEQ -> pc = 0, 4, 8, 12; link_we=0 throughout.
- pc=0x100, BR with br_offset=0x000010 -> next pc = 0x100+0x40+8 = 0x148. Then br_offset=0xFFFFFE (-2) from 0x148 -> 0x148-8+8 = 0x148.
- pc=0x200, BL with offset 0x20 -> pc=0x288, link_we=1 for one cycle, link_addr=0x204, ras_count=1. Then RET -> pc=0x204, ras_count=0.
- RAS_DEPTH=4: 5 nested BLs starting at pc=0x0 -> ras_overflow pulses on the 5th. Then 4 RETs return the 4 newest link addresses in LIFO order; the 5th RET gives pc+4 and ras_underflow=1.
- stall=1 for 3 cycles with ctl_kind=BR applied -> pc, ras_count unchanged, no pulses. Deassert with SEQ -> pc advances by 4 only.
- Assert reset in the same cycle as BL from a non-empty RAS -> pc=RESET_PC, ras_count=0, link_we=0 on the next edge.
